// File: rtl/pool_note_player.sv
// pool_note_player: reader side of the note pool. Draws a random pool address with an LFSR,
// reads the note index stored there and plays it as a square wave on speaker for a fixed time.
module pool_note_player #(
    parameter int unsigned POOL_DEPTH = 100,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned NOTE_W     = 4,
    parameter int unsigned NOTE_TICKS = 12500000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              enable,
    input  logic              pool_ready,
    output logic              pool_rd_en,
    output logic [ADDR_W-1:0] pool_addr,
    input  logic [NOTE_W-1:0] pool_data,
    output logic [NOTE_W-1:0] note_index,
    output logic              note_valid,
    output logic              busy,
    output logic              speaker
);

    localparam int unsigned DUR_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DRAW = 2'd1;
    localparam logic [1:0] READ = 2'd2;
    localparam logic [1:0] PLAY = 2'd3;

    logic [1:0]        state;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_shift;
    logic [15:0]       lfsr_next;
    logic              lfsr_fb;
    logic [ADDR_W-1:0] cand;
    logic              cand_ok;
    logic [16:0]       tone_cnt;
    logic [16:0]       half_period;
    logic [16:0]       hp_lookup;
    logic              rest;
    logic              rest_lookup;
    logic [DUR_W-1:0]  dur_cnt;
    logic              dur_last;
    logic              tone_wrap;

    // Fibonacci LFSR, taps 16,14,13,11; an all-zero state is replaced by the seed.
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign lfsr_shift = {lfsr[14:0], lfsr_fb};
    assign lfsr_next  = (lfsr_shift == 16'h0000) ? LFSR_SEED : lfsr_shift;

    // Rejection sampling: only candidates inside the pool are accepted.
    assign cand    = lfsr[ADDR_W-1:0];
    assign cand_ok = (32'(cand) < POOL_DEPTH);

    assign dur_last  = (dur_cnt == DUR_W'(NOTE_TICKS - 1));
    assign tone_wrap = (tone_cnt == half_period - 17'd1);
    assign busy      = (state != IDLE);

    // Half-period lookup for the note being read; indices past the table are rests.
    always_comb begin
        hp_lookup   = 17'd0;
        rest_lookup = 1'b0;
        case (32'(pool_data))
            0:       hp_lookup = 17'd95556;
            1:       hp_lookup = 17'd90193;
            2:       hp_lookup = 17'd85131;
            3:       hp_lookup = 17'd80353;
            4:       hp_lookup = 17'd75843;
            5:       hp_lookup = 17'd71586;
            6:       hp_lookup = 17'd67569;
            7:       hp_lookup = 17'd63776;
            8:       hp_lookup = 17'd60197;
            9:       hp_lookup = 17'd56818;
            10:      hp_lookup = 17'd53629;
            11:      hp_lookup = 17'd50619;
            12:      hp_lookup = 17'd47778;
            default: rest_lookup = 1'b1;
        endcase
    end

    // Control FSM, LFSR, counters and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            pool_rd_en  <= 1'b0;
            pool_addr   <= '0;
            note_index  <= '0;
            note_valid  <= 1'b0;
            speaker     <= 1'b0;
            tone_cnt    <= '0;
            dur_cnt     <= '0;
            half_period <= '0;
            rest        <= 1'b0;
        end else begin
            note_valid <= 1'b0;
            pool_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    speaker <= 1'b0;
                    if (enable && pool_ready) begin
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    lfsr <= lfsr_next;
                    if (cand_ok) begin
                        pool_addr  <= cand;
                        pool_rd_en <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    // First READ cycle is the strobe cycle; pool_data is valid on the second.
                    if (!pool_rd_en) begin
                        note_index  <= pool_data;
                        half_period <= hp_lookup;
                        rest        <= rest_lookup;
                        tone_cnt    <= '0;
                        dur_cnt     <= '0;
                        speaker     <= 1'b0;
                        note_valid  <= 1'b1;
                        state       <= PLAY;
                    end
                end
                PLAY: begin
                    if (dur_last) begin
                        speaker  <= 1'b0;
                        tone_cnt <= '0;
                        dur_cnt  <= '0;
                        state    <= (enable && pool_ready) ? DRAW : IDLE;
                    end else begin
                        dur_cnt <= dur_cnt + DUR_W'(1);
                        if (tone_wrap) begin
                            tone_cnt <= '0;
                            if (!rest) begin
                                speaker <= ~speaker;
                            end
                        end else begin
                            tone_cnt <= tone_cnt + 17'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_note_player.sv
// Bench for pool_note_player. Four instances run side by side on one clock: a short-note
// instance (random pool, address/note scoreboard, enable drop) and three long-note instances
// (tone timing, rest note, reset in the middle of a sounding note).
module tb_pool_note_player;

    localparam int unsigned SHORT_TICKS = 16;
    localparam int unsigned LONG_TICKS  = 60000;
    localparam int unsigned DEPTH       = 100;
    localparam int unsigned NOTES       = 2000;
    localparam int unsigned FIRST_ADDR  = 97;  // 16'hACE1 & 7'h7F, accepted on the first draw

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Short-note instance: random pool.
    logic       s_rst = 1'b1, s_en = 1'b0, s_rdy = 1'b0;
    logic       s_rd, s_nv, s_busy, s_spk;
    logic [6:0] s_addr;
    logic [3:0] s_data = 4'd0, s_idx;
    logic [3:0] s_pool [DEPTH];

    pool_note_player #(.NOTE_TICKS(SHORT_TICKS)) u_short (
        .CLOCK_50(clk), .reset(s_rst), .enable(s_en), .pool_ready(s_rdy),
        .pool_rd_en(s_rd), .pool_addr(s_addr), .pool_data(s_data),
        .note_index(s_idx), .note_valid(s_nv), .busy(s_busy), .speaker(s_spk)
    );

    always @(posedge clk) if (s_rd) s_data <= s_pool[s_addr];

    // Long-note instance: every entry is note 9.
    logic       l_rst = 1'b1, l_en = 1'b0, l_rdy = 1'b0;
    logic       l_rd, l_nv, l_busy, l_spk;
    logic [6:0] l_addr;
    logic [3:0] l_data = 4'd0, l_idx;

    pool_note_player #(.NOTE_TICKS(LONG_TICKS)) u_long (
        .CLOCK_50(clk), .reset(l_rst), .enable(l_en), .pool_ready(l_rdy),
        .pool_rd_en(l_rd), .pool_addr(l_addr), .pool_data(l_data),
        .note_index(l_idx), .note_valid(l_nv), .busy(l_busy), .speaker(l_spk)
    );

    always @(posedge clk) if (l_rd) l_data <= 4'd9;

    // Reset instance: every entry is note 12.
    logic       r_rst = 1'b1, r_en = 1'b0, r_rdy = 1'b0;
    logic       r_rd, r_nv, r_busy, r_spk;
    logic [6:0] r_addr;
    logic [3:0] r_data = 4'd0, r_idx;

    pool_note_player #(.NOTE_TICKS(LONG_TICKS)) u_rst (
        .CLOCK_50(clk), .reset(r_rst), .enable(r_en), .pool_ready(r_rdy),
        .pool_rd_en(r_rd), .pool_addr(r_addr), .pool_data(r_data),
        .note_index(r_idx), .note_valid(r_nv), .busy(r_busy), .speaker(r_spk)
    );

    always @(posedge clk) if (r_rd) r_data <= 4'd12;

    // Rest instance: every entry is note 14.
    logic       q_rst = 1'b1, q_en = 1'b0, q_rdy = 1'b0;
    logic       q_rd, q_nv, q_busy, q_spk;
    logic [6:0] q_addr;
    logic [3:0] q_data = 4'd0, q_idx;

    pool_note_player #(.NOTE_TICKS(LONG_TICKS)) u_rest (
        .CLOCK_50(clk), .reset(q_rst), .enable(q_en), .pool_ready(q_rdy),
        .pool_rd_en(q_rd), .pool_addr(q_addr), .pool_data(q_data),
        .note_index(q_idx), .note_valid(q_nv), .busy(q_busy), .speaker(q_spk)
    );

    always @(posedge clk) if (q_rd) q_data <= 4'd14;

    // Scoreboard state for the short instance.
    logic [15:0] sb_lfsr = 16'hACE1;
    logic [3:0]  exp_q [$];
    int unsigned t_q [$];
    bit          hit [DEPTH];
    int unsigned notes_done = 0;
    bit          sb_on = 1'b0;
    bit          done_s = 1'b0, done_l = 1'b0, done_r = 1'b0, done_q = 1'b0;

    // Predict each drawn address from an LFSR model; check the note that comes back.
    initial begin : sb_mon
        logic [6:0]  cand;
        logic        fb;
        int unsigned t;
        forever begin
            @(negedge clk);
            if (sb_on && s_rd) begin
                do begin
                    cand    = sb_lfsr[6:0];
                    fb      = sb_lfsr[15] ^ sb_lfsr[13] ^ sb_lfsr[12] ^ sb_lfsr[10];
                    sb_lfsr = {sb_lfsr[14:0], fb};
                    if (sb_lfsr == 16'h0000) sb_lfsr = 16'hACE1;
                end while (32'(cand) >= DEPTH);
                check_eq("addr_seq", 32'(s_addr), 32'(cand));
                check_eq("addr_range", 32'(32'(s_addr) < DEPTH), 1);
                if (32'(s_addr) < DEPTH) hit[s_addr] = 1'b1;
                exp_q.push_back(s_pool[cand]);
                t_q.push_back(cyc);
            end
            if (sb_on && s_nv) begin
                check_eq("sb_has_entry", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    t = t_q.pop_front();
                    check_eq("note_index", 32'(s_idx), 32'(exp_q.pop_front()));
                    check_eq("rd_to_nv", cyc - t, 2);
                end
                notes_done++;
            end
        end
    end

    // Short instance: reset, idle, random-pool run, enable drop and re-enable.
    initial begin : short_seq
        int n;
        int rd_cnt;
        int nh;
        foreach (s_pool[i]) s_pool[i] = 4'($urandom_range(0, 15));
        s_rst = 1'b1; s_en = 1'b1; s_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_speaker", 32'(s_spk), 0);
        check_eq("rst_rd_en", 32'(s_rd), 0);
        check_eq("rst_addr", 32'(s_addr), 0);
        check_eq("rst_index", 32'(s_idx), 0);
        check_eq("rst_valid", 32'(s_nv), 0);
        check_eq("rst_busy", 32'(s_busy), 0);
        s_rst = 1'b0;
        sb_on = 1'b1;
        rd_cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (s_rd) rd_cnt++;
        end
        check_eq("idle_no_rd", 32'(rd_cnt), 0);
        check_eq("idle_busy", 32'(s_busy), 0);
        s_rdy = 1'b1;
        n = 0;
        while (notes_done < NOTES && n < int'(NOTES * 40)) begin
            @(negedge clk);
            n++;
        end
        check_eq("notes_played", 32'(notes_done >= NOTES), 1);
        nh = 0;
        foreach (hit[i]) if (hit[i]) nh++;
        check_eq("all_addr_hit", 32'(nh), DEPTH);
        n = 0;
        while (!s_nv && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drop_nv_seen", 32'(s_nv), 1);
        s_en = 1'b0;
        repeat (SHORT_TICKS - 1) @(negedge clk);
        check_eq("drop_busy_last", 32'(s_busy), 1);
        @(negedge clk);
        check_eq("drop_busy_end", 32'(s_busy), 0);
        check_eq("drop_speaker", 32'(s_spk), 0);
        rd_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (s_rd) rd_cnt++;
        end
        check_eq("drop_no_rd", 32'(rd_cnt), 0);
        check_eq("drop_idle", 32'(s_busy), 0);
        s_en = 1'b1;
        @(negedge clk);
        check_eq("reenable_draw", 32'(s_busy), 1);
        done_s = 1'b1;
    end

    // Long instance: read latency, first address, tone rise time, note end, next draw.
    initial begin : long_seq
        int          n;
        int unsigned t_rd;
        int unsigned t_nv;
        l_rst = 1'b1; l_en = 1'b1; l_rdy = 1'b1;
        repeat (3) @(negedge clk);
        l_rst = 1'b0;
        n = 0;
        while (!l_rd && n < 100) begin @(negedge clk); n++; end
        check_eq("l_rd_seen", 32'(l_rd), 1);
        check_eq("l_first_addr", 32'(l_addr), FIRST_ADDR);
        t_rd = cyc;
        n = 0;
        while (!l_nv && n < 10) begin @(negedge clk); n++; end
        check_eq("l_nv_seen", 32'(l_nv), 1);
        check_eq("l_rd_to_nv", cyc - t_rd, 2);
        check_eq("l_note_index", 32'(l_idx), 9);
        check_eq("l_spk_start", 32'(l_spk), 0);
        t_nv = cyc;
        n = 0;
        while (!l_spk && n < int'(LONG_TICKS)) begin @(negedge clk); n++; end
        check_eq("l_rise_time", cyc - t_nv, 56818);
        n = 0;
        while (l_spk && n < int'(LONG_TICKS)) begin @(negedge clk); n++; end
        check_eq("l_note_end", cyc - t_nv, LONG_TICKS);
        check_eq("l_busy_after", 32'(l_busy), 1);
        n = 0;
        while (!l_rd && n < 200) begin @(negedge clk); n++; end
        check_eq("l_next_rd", 32'(l_rd), 1);
        done_l = 1'b1;
    end

    // Reset instance: reset while speaker is high, then the draw sequence restarts.
    initial begin : rst_seq
        int         n;
        logic [6:0] a0;
        r_rst = 1'b1; r_en = 1'b1; r_rdy = 1'b1;
        repeat (3) @(negedge clk);
        r_rst = 1'b0;
        n = 0;
        while (!r_rd && n < 100) begin @(negedge clk); n++; end
        check_eq("r_rd_seen", 32'(r_rd), 1);
        check_eq("r_first_addr", 32'(r_addr), FIRST_ADDR);
        a0 = r_addr;
        n = 0;
        while (!r_spk && n < int'(LONG_TICKS)) begin @(negedge clk); n++; end
        check_eq("r_spk_high", 32'(r_spk), 1);
        r_rst = 1'b1;
        @(negedge clk);
        check_eq("r_speaker", 32'(r_spk), 0);
        check_eq("r_busy", 32'(r_busy), 0);
        check_eq("r_rd_en", 32'(r_rd), 0);
        check_eq("r_valid", 32'(r_nv), 0);
        check_eq("r_index", 32'(r_idx), 0);
        check_eq("r_addr", 32'(r_addr), 0);
        check_eq("r_lfsr", 32'(u_rst.lfsr), 32'h0000ACE1);
        r_rst = 1'b0;
        n = 0;
        while (!r_rd && n < 100) begin @(negedge clk); n++; end
        check_eq("r_rd_again", 32'(r_rd), 1);
        check_eq("r_same_addr", 32'(r_addr), 32'(a0));
        done_r = 1'b1;
    end

    // Rest instance: note 14 keeps the speaker low for the whole note.
    initial begin : rest_seq
        int n;
        int hi;
        q_rst = 1'b1; q_en = 1'b1; q_rdy = 1'b1;
        repeat (3) @(negedge clk);
        q_rst = 1'b0;
        n = 0;
        while (!q_nv && n < 200) begin @(negedge clk); n++; end
        check_eq("q_nv_seen", 32'(q_nv), 1);
        check_eq("q_note_index", 32'(q_idx), 14);
        hi = 0;
        repeat (LONG_TICKS) begin
            if (q_spk) hi++;
            @(negedge clk);
        end
        check_eq("q_silent", 32'(hi), 0);
        check_eq("q_busy_after", 32'(q_busy), 1);
        done_q = 1'b1;
    end

    initial begin : finisher
        wait (done_s && done_l && done_r && done_q);
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog: got timeout, expected all sequences done (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
